// File: rtl/tdc_frame_tx_if.sv
// TDC word input, byte-stream output and status for tdc_frame_tx.
// master = framer side, slave = TDC/consumer side.
interface tdc_frame_tx_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [36:0]   time_in;
  logic          dval;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [LW-1:0] fifo_level;
  logic [15:0]   drop_cnt;
  logic          busy;

  modport master (
    input  time_in, dval, tx_ready,
    output tx_data, tx_valid, fifo_level, drop_cnt, busy
  );

  modport slave (
    output time_in, dval, tx_ready,
    input  tx_data, tx_valid, fifo_level, drop_cnt, busy
  );
endinterface

// File: rtl/tdc_frame_tx.sv
// Buffers 37-bit TDC words and sends each as a 6-byte frame (sync, flag|w[36:32], 4 bytes), MSB first.
// First byte valid 2 edges after dval; tx_data/state hold under !tx_ready; a full FIFO drops and counts.
module tdc_frame_tx #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic           pll_clk,
  input logic           rst,
  tdc_frame_tx_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, B4, B3, B2, B1, B0} state_t;

  state_t        state_q, state_d;
  logic [36:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [36:0]   shift_q, shift_d;
  logic          dflag_q, dflag_d;
  logic          drop_pend_q, drop_pend_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d;
  logic          full, empty, pop, wr_en, drop, accept;

  assign full   = (level_q == DEPTH_L);
  assign empty  = (level_q == '0);
  assign pop    = (state_q == IDLE) && !empty;
  // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken.
  assign wr_en  = bus.dval && (!full || pop);
  assign drop   = bus.dval && full && !pop;
  assign accept = tx_valid_q && bus.tx_ready;

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    shift_d     = pop ? mem_q[rd_ptr_q] : shift_q;
    dflag_d     = pop ? drop_pend_q : dflag_q;
    drop_pend_d = pop ? drop : (drop_pend_q | drop);
    drop_cnt_d  = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge pll_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.time_in;
  end

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      shift_q     <= '0;
      dflag_q     <= 1'b0;
      drop_pend_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q     <= level_d;
      shift_q     <= shift_d;
      dflag_q     <= dflag_d;
      drop_pend_q <= drop_pend_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop)    state_d = HDR;
      HDR:     if (accept) state_d = B4;
      B4:      if (accept) state_d = B3;
      B3:      if (accept) state_d = B2;
      B2:      if (accept) state_d = B1;
      B1:      if (accept) state_d = B0;
      B0:      if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered byte matches state_q.
  always_comb begin
    tx_valid_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE) || (level_d != '0);
    case (state_d)
      HDR:     tx_data_d = SYNC_BYTE;
      B4:      tx_data_d = {dflag_q, 2'b00, shift_q[36:32]};
      B3:      tx_data_d = shift_q[31:24];
      B2:      tx_data_d = shift_q[23:16];
      B1:      tx_data_d = shift_q[15:8];
      B0:      tx_data_d = shift_q[7:0];
      default: tx_data_d = '0;
    endcase
  end

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.fifo_level = level_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.busy       = busy_q;
endmodule
